// File: rtl/dipsw_pio_debounce_if.sv
// rtl/dipsw_pio_debounce_if.sv - Avalon-MM slave bus bundle for the switch PIO
interface dipsw_pio_debounce_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/dipsw_pio_debounce.sv
// rtl/dipsw_pio_debounce.sv - debounced switch/button input PIO with edge capture and irq
module dipsw_pio_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_port,
    dipsw_pio_debounce_if.slave  bus
);
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync0_q, sync0_d;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] deb_prev_q, deb_prev_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    // Two-flop synchroniser per input bit.
    always_comb begin
        sync0_d = in_port;
        sync1_d = sync0_q;
    end

    // Per-bit stability counter: a new level is accepted only after it has
    // disagreed with the debounced value for DEBOUNCE_CYCLES straight cycles.
    always_comb begin
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync1_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync1_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Edge detection on the debounced value, W1C capture (set beats clear) and register writes.
    always_comb begin
        wr_en = bus.chipselect & ~bus.write_n;
        wdata = bus.writedata[WIDTH-1:0];
        rise  = deb_q & ~deb_prev_q & rise_en_q;
        fall  = ~deb_q & deb_prev_q & fall_en_q;

        edge_capture_d = edge_capture_q;
        irq_mask_d     = irq_mask_q;
        rise_en_d      = rise_en_q;
        fall_en_d      = fall_en_q;
        if (wr_en) begin
            case (bus.address)
                3'd2:    irq_mask_d     = wdata;
                3'd3:    edge_capture_d = edge_capture_q & ~wdata;
                3'd4:    rise_en_d      = wdata;
                3'd5:    fall_en_d      = wdata;
                default: ;
            endcase
        end
        edge_capture_d = edge_capture_d | rise | fall;

        irq_d = |(edge_capture_q & irq_mask_q);
    end

    // Read mux sampled every cycle from the current address, zero-extended.
    always_comb begin
        case (bus.address)
            3'd0:    readdata_d = 32'(deb_q);
            3'd1:    readdata_d = 32'(sync1_q);
            3'd2:    readdata_d = 32'(irq_mask_q);
            3'd3:    readdata_d = 32'(edge_capture_q);
            3'd4:    readdata_d = 32'(rise_en_q);
            3'd5:    readdata_d = 32'(fall_en_q);
            default: readdata_d = 32'd0;
        endcase
    end

    // State registers; edge enables come up all ones so any edge is captured by default.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0_q        <= '0;
            sync1_q        <= '0;
            deb_q          <= '0;
            deb_prev_q     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            edge_capture_q <= '0;
            irq_mask_q     <= '0;
            rise_en_q      <= '1;
            fall_en_q      <= '1;
            readdata_q     <= '0;
            irq_q          <= 1'b0;
        end else begin
            sync0_q        <= sync0_d;
            sync1_q        <= sync1_d;
            deb_q          <= deb_d;
            deb_prev_q     <= deb_prev_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            edge_capture_q <= edge_capture_d;
            irq_mask_q     <= irq_mask_d;
            rise_en_q      <= rise_en_d;
            fall_en_q      <= fall_en_d;
            readdata_q     <= readdata_d;
            irq_q          <= irq_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_dipsw_pio_debounce.sv
// tb/tb_dipsw_pio_debounce.sv - self-checking bench for dipsw_pio_debounce
module tb_dipsw_pio_debounce;
    localparam int W  = 4;
    localparam int DC = 4;

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic [W-1:0] in_port = '0;
    logic         mon_en  = 1'b0;

    dipsw_pio_debounce_if bus();

    dipsw_pio_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nbad = 0;

    // Reference model: a bit's debounced level flips when the last DC
    // synchronised samples all disagree with it.
    logic [W-1:0] m_sync0, m_sync, m_deb, m_deb_prev, m_cap, m_mask, m_ren, m_fen;
    logic [31:0]  m_rd;
    logic         m_irq;
    logic [W-1:0] m_win[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sync0 = '0; m_sync = '0; m_deb = '0; m_deb_prev = '0;
        m_cap = '0; m_mask = '0; m_ren = '1; m_fen = '1;
        m_rd = '0; m_irq = 1'b0;
        m_win.delete();
        for (int k = 0; k < DC; k++) m_win.push_back('0);
    endtask

    task automatic model_step();
        logic         wr;
        logic [W-1:0] wd, ev, clr, deb_n;
        logic [31:0]  rd_n;
        logic         irq_n;
        bit           all_diff;
        wr = bus.chipselect && !bus.write_n;
        wd = bus.writedata[W-1:0];
        case (bus.address)
            3'd0:    rd_n = 32'(m_deb);
            3'd1:    rd_n = 32'(m_sync);
            3'd2:    rd_n = 32'(m_mask);
            3'd3:    rd_n = 32'(m_cap);
            3'd4:    rd_n = 32'(m_ren);
            3'd5:    rd_n = 32'(m_fen);
            default: rd_n = 32'd0;
        endcase
        irq_n = |(m_cap & m_mask);
        ev    = (m_deb & ~m_deb_prev & m_ren) | (~m_deb & m_deb_prev & m_fen);
        clr   = (wr && bus.address == 3'd3) ? wd : '0;
        m_win.push_back(m_sync);
        void'(m_win.pop_front());
        deb_n = m_deb;
        for (int i = 0; i < W; i++) begin
            all_diff = 1'b1;
            foreach (m_win[k]) if (m_win[k][i] == m_deb[i]) all_diff = 1'b0;
            if (all_diff) deb_n[i] = ~m_deb[i];
        end
        m_cap = (m_cap & ~clr) | ev;
        if (wr) begin
            case (bus.address)
                3'd2:    m_mask = wd;
                3'd4:    m_ren  = wd;
                3'd5:    m_fen  = wd;
                default: ;
            endcase
        end
        m_deb_prev = m_deb;
        m_deb      = deb_n;
        m_sync     = m_sync0;
        m_sync0    = in_port;
        m_rd       = rd_n;
        m_irq      = irq_n;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("model_rd", bus.readdata, m_rd);
                check("model_irq", 32'(bus.irq), 32'(m_irq));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        bus.address = a;
        @(negedge clk);
        d = bus.readdata;
    endtask

    initial begin
        logic [31:0] v;
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        tick(3);
        reset  = 1'b0;
        mon_en = 1'b1;
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", 32'(bus.irq), 32'h0);
        bus_rd(3'd4, v); check("rst_rise_en", v, 32'hF);
        bus_rd(3'd5, v); check("rst_fall_en", v, 32'hF);

        // Latency: deb updates 6 edges after the change, readdata one edge later.
        bus.address = 3'd0;
        in_port = 4'h1;
        tick(6); check("data_pre", bus.readdata, 32'h0);
        tick(1); check("data_lat", bus.readdata, 32'h1);
        bus_rd(3'd3, v); check("cap_rise0", v, 32'h1);
        check("irq_masked", 32'(bus.irq), 32'h0);
        bus_wr(3'd2, 32'h1);
        check("irq_before", 32'(bus.irq), 32'h0);
        tick(1); check("irq_unmasked", 32'(bus.irq), 32'h1);

        // Short glitch is rejected, a held level is accepted.
        bus_wr(3'd3, 32'hF);
        in_port = 4'h5; tick(3); in_port = 4'h1; tick(12);
        bus_rd(3'd0, v); check("glitch_data", v, 32'h1);
        bus_rd(3'd3, v); check("glitch_cap", v, 32'h0);
        check("glitch_irq", 32'(bus.irq), 32'h0);
        in_port = 4'h5; tick(12);
        bus_rd(3'd0, v); check("held_data", v, 32'h5);
        bus_wr(3'd3, 32'hF);

        // Fall-only enable on bit 1.
        bus_wr(3'd4, 32'h0); bus_wr(3'd5, 32'h2);
        in_port = 4'h7; tick(10);
        in_port = 4'h5; tick(10);
        bus_rd(3'd3, v); check("fall_only", v, 32'h2);

        // Partial W1C.
        bus_wr(3'd4, 32'hF); bus_wr(3'd5, 32'hF);
        in_port = 4'hD; tick(10);
        bus_rd(3'd3, v); check("cap_a", v, 32'hA);
        bus_wr(3'd3, 32'h8);
        bus_rd(3'd3, v); check("w1c_partial", v, 32'h2);

        // Clear on the same edge a bit-1 capture fires: set wins.
        bus_wr(3'd3, 32'hF);
        bus_rd(3'd3, v); check("cap_cleared", v, 32'h0);
        in_port = 4'hF; tick(6);
        bus_wr(3'd3, 32'h2);
        bus_rd(3'd3, v); check("w1c_race", v, 32'h2);

        // Asynchronous reset mid-debounce with pending capture/irq.
        in_port = 4'h0; tick(12);
        bus.address = 3'd3;
        in_port = 4'hF; tick(3);
        check("pre_rst_cap", bus.readdata, 32'hF);
        #2 reset = 1'b1;
        #1;
        check("async_rd", bus.readdata, 32'h0);
        check("async_irq", 32'(bus.irq), 32'h0);
        @(negedge clk); reset = 1'b0;
        tick(12);
        bus_rd(3'd3, v); check("post_rst_cap", v, 32'hF);
        bus_rd(3'd2, v); check("post_rst_mask", v, 32'h0);

        // Randomised traffic, checked every cycle against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 4) == 0) in_port[$urandom_range(0, W-1)] ^= 1'b1;
            bus.address    = 3'($urandom_range(0, 7));
            bus.writedata  = $urandom;
            bus.chipselect = ($urandom_range(0, 3) != 0);
            bus.write_n    = ($urandom_range(0, 5) != 0);
            if (c == 700) begin
                #2 reset = 1'b1;
                @(negedge clk); reset = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", nchk, nbad);
        $finish;
    end
endmodule
